// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding, width helpers and butterfly-span mask for the FFT sequencer
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  // Per-bank address width: four banks share the N points.
  function automatic int addr_width(input int log2n);
    return log2n - 2;
  endfunction

  // Twiddle index width covers N/2 twiddle factors.
  function automatic int tw_width(input int log2n);
    return log2n - 1;
  endfunction

  // Partner-address mask for a stage; later stages pair inside the same bank row.
  function automatic logic [9:0] stage_mask(input int addr_w, input int stage);
    logic [9:0] m;
    m = '0;
    if (stage < addr_w) m = 10'(1) << (addr_w - 1 - stage);
    return m;
  endfunction

endpackage

// File: rtl/addr_delay_line.sv
// rtl/addr_delay_line.sv - WIDTH x LATENCY shift register with hold, aligns read-side data to write side
module addr_delay_line #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [LATENCY];

  // Shift one tap per unheld cycle; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) taps[i] <= '0;
    end else if (!hold) begin
      taps[0] <= din;
      for (int i = 1; i < LATENCY; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[LATENCY-1];

endmodule

// File: rtl/fft_addr_sequencer.sv
// rtl/fft_addr_sequencer.sv - stage FSM, bank read/write address and twiddle index generation for radix-2 FFT
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter  int LOG2N      = 5,
  parameter  int BF_LATENCY = 3,
  localparam int ADDR_W     = addr_width(LOG2N),
  localparam int TW_W       = tw_width(LOG2N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [3:0]        stage_num,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] wr_addr2,
  output logic [ADDR_W-1:0] wr_addr3,
  output logic [TW_W-1:0]   tw_idx
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LAT_W  = $clog2(BF_LATENCY + 1);
  localparam int CNT_W  = (ADDR_W > LAT_W) ? ADDR_W : LAT_W;
  localparam int PIPE_W = 1 + 4 * ADDR_W;

  localparam logic [CNT_W-1:0] CNT_RUN_LAST   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DRAIN_LAST = CNT_W'(BF_LATENCY - 1);
  localparam logic [3:0]       STAGE_LAST     = 4'(LOG2N - 1);

  fft_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [3:0]        stage, stage_nx;
  logic              run_phase;
  logic [9:0]        mask_full;
  logic [ADDR_W-1:0] rd_mask;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] rd_pair;
  logic [TW_W-1:0]   tw_base;
  logic [PIPE_W-1:0] pipe_in;
  logic [PIPE_W-1:0] pipe_out;

  // State, counter and stage registers; stall is folded into the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      stage <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      stage <= stage_nx;
    end
  end

  // Next-state: RUN walks the bank rows, DRAIN waits out the butterfly pipeline.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stage_nx = stage;
    if (!stall) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            cnt_nx   = '0;
            stage_nx = '0;
          end
        end
        RUN: begin
          if (cnt == CNT_RUN_LAST) begin
            state_nx = DRAIN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == CNT_DRAIN_LAST) begin
            cnt_nx = '0;
            if (stage == STAGE_LAST) begin
              state_nx = DONE;
            end else begin
              state_nx = RUN;
              stage_nx = stage + 4'd1;
            end
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  assign run_phase = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stage_num = stage;
  assign rd_en     = run_phase & ~stall;

  // Addresses follow the registered counter and stay put across a stall.
  assign mask_full = stage_mask(ADDR_W, int'(stage));
  assign rd_mask   = mask_full[ADDR_W-1:0];
  assign rd_base   = run_phase ? cnt[ADDR_W-1:0] : '0;
  assign rd_pair   = run_phase ? (cnt[ADDR_W-1:0] ^ rd_mask) : '0;
  assign tw_base   = TW_W'(rd_base);
  assign tw_idx    = tw_base << stage;

  assign rd_addr0 = rd_base;
  assign rd_addr1 = rd_base;
  assign rd_addr2 = rd_pair;
  assign rd_addr3 = rd_pair;

  assign pipe_in = {rd_en, rd_base, rd_base, rd_pair, rd_pair};

  addr_delay_line #(
    .WIDTH   (PIPE_W),
    .LATENCY (BF_LATENCY)
  ) u_wr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (stall),
    .din   (pipe_in),
    .dout  (pipe_out)
  );

  assign wr_en    = pipe_out[PIPE_W-1] & ~stall;
  assign wr_addr0 = pipe_out[4*ADDR_W-1 -: ADDR_W];
  assign wr_addr1 = pipe_out[3*ADDR_W-1 -: ADDR_W];
  assign wr_addr2 = pipe_out[2*ADDR_W-1 -: ADDR_W];
  assign wr_addr3 = pipe_out[ADDR_W-1 -: ADDR_W];

endmodule
